// File: rtl/dma_priority_arbiter.sv
// DMA channel-priority and bus-hold sequencer: qualifies DREQs, requests the bus, grants one channel.
// Latency: request -> HRQ one edge; HLDA sampled high -> DACK active on that same edge.
// Backpressure: the grant is held until SVC_DONE or HLDA revoke; the bus is released before the next arbitration.
module dma_priority_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int DREQ_ACT_HI = 1,
    parameter int DACK_ACT_HI = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] MASK,
    input  logic              CTRL_EN,
    input  logic              ROTATE,
    input  logic              HLDA,
    input  logic              SVC_DONE,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [CH_W-1:0]   ACTIVE_CH,
    output logic              BUSY
);

    localparam logic              DREQ_ON   = (DREQ_ACT_HI != 0);
    localparam logic              DACK_ON   = (DACK_ACT_HI != 0);
    localparam logic [NUM_CH-1:0] DACK_IDLE = {NUM_CH{~DACK_ON}};
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, HREQ, SVC, REL} state_t;

    state_t              state, state_n;
    logic                hrq_n, busy_n;
    logic [NUM_CH-1:0]   dack_n;
    logic [CH_W-1:0]     ch_n;
    logic [CH_W-1:0]     ptr, ptr_n;

    logic [NUM_CH-1:0]   req;
    logic [CH_W-1:0]     start;
    logic [CH_W-1:0]     win_idx;
    logic                win_found;
    logic [CH_W-1:0]     cand;
    logic [NUM_CH-1:0]   win_oh;
    logic [CH_W-1:0]     ptr_after;

    // Qualify raw pins into an active-high request vector.
    always_comb begin
        req = (DREQ_ON ? DREQ : ~DREQ) & ~MASK & {NUM_CH{CTRL_EN}};
    end

    // Pick the first requester at or after the search start, wrapping modulo NUM_CH.
    // Fixed mode always starts at 0 even if the pointer has not been cleared yet.
    always_comb begin
        start     = ROTATE ? ptr : '0;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(start) + k >= NUM_CH)
                cand = CH_W'(int'(start) + k - NUM_CH);
            else
                cand = CH_W'(int'(start) + k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_oh    = NUM_CH'(1) << win_idx;
        ptr_after = (ACTIVE_CH == LAST_CH) ? '0 : ACTIVE_CH + 1'b1;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state;
        hrq_n   = HRQ;
        busy_n  = BUSY;
        dack_n  = DACK;
        ch_n    = ACTIVE_CH;
        ptr_n   = ROTATE ? ptr : '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = HREQ;
                    hrq_n   = 1'b1;
                end
            end
            HREQ: begin
                if (HLDA && win_found) begin
                    state_n = SVC;
                    dack_n  = DACK_ON ? win_oh : ~win_oh;
                    ch_n    = win_idx;
                    busy_n  = 1'b1;
                end else if (!(|req)) begin
                    state_n = IDLE;
                    hrq_n   = 1'b0;
                end
            end
            SVC: begin
                // Grant is frozen here; only completion or a hold revoke ends it.
                if (SVC_DONE || !HLDA) begin
                    state_n = REL;
                    dack_n  = DACK_IDLE;
                    busy_n  = 1'b0;
                    hrq_n   = 1'b0;
                    ptr_n   = ROTATE ? ptr_after : '0;
                end
            end
            REL: begin
                if (!HLDA)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            HRQ       <= 1'b0;
            BUSY      <= 1'b0;
            DACK      <= DACK_IDLE;
            ACTIVE_CH <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_n;
            HRQ       <= hrq_n;
            BUSY      <= busy_n;
            DACK      <= dack_n;
            ACTIVE_CH <= ch_n;
            ptr       <= ptr_n;
        end
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter with default parameters (4 ch, DREQ active-high, DACK active-low).
// Inputs change 1ns after posedge; outputs are compared at that same point.
// A negedge monitor checks DACK one-hotness and that an active DACK implies BUSY and HRQ.
module tb_dma_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dreq, mask;
    logic       ctrl_en, rotate, hlda, svc_done;
    logic       hrq, busy;
    logic [3:0] dack;
    logic [1:0] active_ch;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    dma_priority_arbiter #(.NUM_CH(4), .DREQ_ACT_HI(1), .DACK_ACT_HI(0)) dut (
        .CLK(clk), .RESET(rst), .DREQ(dreq), .MASK(mask), .CTRL_EN(ctrl_en),
        .ROTATE(rotate), .HLDA(hlda), .SVC_DONE(svc_done),
        .HRQ(hrq), .DACK(dack), .ACTIVE_CH(active_ch), .BUSY(busy)
    );

    always #5 clk = ~clk;

    // Continuous invariants on the active-low DACK bus.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(~dack)) begin
                errors++;
                $display("FAIL dack_onehot0 dack=%b", dack);
            end
            if (dack != 4'hF) begin
                checks++;
                if (!(busy && hrq)) begin
                    errors++;
                    $display("FAIL dack_implies_busy_hrq dack=%b busy=%b hrq=%b", dack, busy, hrq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; dreq = 4'hF; mask = 4'h0; ctrl_en = 1'b1;
        rotate = 1'b0; hlda = 1'b0; svc_done = 1'b0;
        tick(); tick();
        checks++;
        if ({hrq, busy, dack, active_ch} !== 8'b0_0_1111_00) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", {hrq, busy, dack, active_ch}, 8'b0_0_1111_00);
        end
        mon_en = 1'b1;
        rst = 1'b0; dreq = 4'h0;
        tick();
        checks++;
        if ({hrq, busy, dack} !== 6'b0_0_1111) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", {hrq, busy, dack}, 6'b0_0_1111);
        end
    endtask

    task automatic test_fixed_priority();
        rotate = 1'b0; dreq = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({hrq, busy, dack} !== 6'b1_0_1111) begin
                errors++;
                $display("FAIL fixed_hreq_wait%0d got=%b exp=%b", c, {hrq, busy, dack}, 6'b1_0_1111);
            end
        end
        hlda = 1'b1;
        tick();
        checks++;
        if ({hrq, busy, dack, active_ch} !== 8'b1_1_1101_01) begin
            errors++;
            $display("FAIL fixed_grant got=%b exp=%b", {hrq, busy, dack, active_ch}, 8'b1_1_1101_01);
        end
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0;
        checks++;
        if ({hrq, busy, dack} !== 6'b0_0_1111) begin
            errors++;
            $display("FAIL fixed_release got=%b exp=%b", {hrq, busy, dack}, 6'b0_0_1111);
        end
        hlda = 1'b0; dreq = 4'h0;
        tick();
    endtask

    task automatic test_ctrl_en_mask();
        ctrl_en = 1'b0; dreq = 4'hF;
        tick(); tick();
        checks++;
        if ({hrq, busy, dack} !== 6'b0_0_1111) begin
            errors++;
            $display("FAIL ctrl_en_block got=%b exp=%b", {hrq, busy, dack}, 6'b0_0_1111);
        end
        ctrl_en = 1'b1; mask = 4'hF;
        tick(); tick();
        checks++;
        if ({hrq, busy, dack} !== 6'b0_0_1111) begin
            errors++;
            $display("FAIL mask_block got=%b exp=%b", {hrq, busy, dack}, 6'b0_0_1111);
        end
        mask = 4'h0; dreq = 4'h0;
        tick();
    endtask

    task automatic test_rotate();
        logic [3:0] one;
        logic [3:0] exp_dack;
        logic [1:0] exp_ch;
        one = 4'b0001;
        rotate = 1'b1; dreq = 4'hF;
        for (int g = 0; g < 5; g++) begin
            exp_ch   = 2'(g % 4);
            exp_dack = ~(one << exp_ch);
            tick();
            hlda = 1'b1;
            tick();
            checks++;
            if ({hrq, busy, dack, active_ch} !== {2'b11, exp_dack, exp_ch}) begin
                errors++;
                $display("FAIL rotate_grant%0d got=%b exp=%b", g, {hrq, busy, dack, active_ch},
                         {2'b11, exp_dack, exp_ch});
            end
            svc_done = 1'b1;
            tick();
            svc_done = 1'b0;
            hlda = 1'b0;
            tick();
        end
        dreq = 4'h0;
        tick();
    endtask

    task automatic test_withdraw();
        dreq = 4'b0100;
        tick();
        checks++;
        if ({hrq, busy, dack} !== 6'b1_0_1111) begin
            errors++;
            $display("FAIL withdraw_hrq got=%b exp=%b", {hrq, busy, dack}, 6'b1_0_1111);
        end
        tick();
        dreq = 4'h0;
        tick();
        checks++;
        if ({hrq, busy, dack} !== 6'b0_0_1111) begin
            errors++;
            $display("FAIL withdraw_drop got=%b exp=%b", {hrq, busy, dack}, 6'b0_0_1111);
        end
        tick();
        checks++;
        if ({hrq, busy, dack} !== 6'b0_0_1111) begin
            errors++;
            $display("FAIL withdraw_idle got=%b exp=%b", {hrq, busy, dack}, 6'b0_0_1111);
        end
    endtask

    task automatic test_abort_mask();
        dreq = 4'b0100;
        tick();
        hlda = 1'b1;
        tick();
        checks++;
        if ({hrq, busy, dack, active_ch} !== 8'b1_1_1011_10) begin
            errors++;
            $display("FAIL abort_grant got=%b exp=%b", {hrq, busy, dack, active_ch}, 8'b1_1_1011_10);
        end
        mask = 4'b0100; dreq = 4'hF;
        tick();
        checks++;
        if ({hrq, busy, dack, active_ch} !== 8'b1_1_1011_10) begin
            errors++;
            $display("FAIL abort_frozen got=%b exp=%b", {hrq, busy, dack, active_ch}, 8'b1_1_1011_10);
        end
        hlda = 1'b0;
        tick();
        checks++;
        if ({hrq, busy, dack} !== 6'b0_0_1111) begin
            errors++;
            $display("FAIL abort_release got=%b exp=%b", {hrq, busy, dack}, 6'b0_0_1111);
        end
        mask = 4'h0;
        tick();
        checks++;
        if (hrq !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_gap got=%b exp=%b", hrq, 1'b0);
        end
        tick();
        hlda = 1'b1;
        tick();
        checks++;
        if ({hrq, busy, dack, active_ch} !== 8'b1_1_0111_11) begin
            errors++;
            $display("FAIL abort_next_ptr got=%b exp=%b", {hrq, busy, dack, active_ch}, 8'b1_1_0111_11);
        end
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0; hlda = 1'b0; dreq = 4'h0;
        tick();
    endtask

    task automatic test_rotate_off();
        rotate = 1'b1; dreq = 4'b0001;
        tick();
        hlda = 1'b1;
        tick();
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0; hlda = 1'b0; dreq = 4'h0;
        tick();
        rotate = 1'b0; dreq = 4'hF;
        tick();
        hlda = 1'b1;
        tick();
        checks++;
        if ({busy, dack, active_ch} !== 7'b1_1110_00) begin
            errors++;
            $display("FAIL rotate_off_fixed got=%b exp=%b", {busy, dack, active_ch}, 7'b1_1110_00);
        end
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0; hlda = 1'b0; dreq = 4'h0;
        tick();
        rotate = 1'b1; dreq = 4'hF;
        tick();
        hlda = 1'b1;
        tick();
        checks++;
        if ({busy, dack, active_ch} !== 7'b1_1110_00) begin
            errors++;
            $display("FAIL rotate_off_ptr_cleared got=%b exp=%b", {busy, dack, active_ch}, 7'b1_1110_00);
        end
        svc_done = 1'b1;
        tick();
        svc_done = 1'b0; hlda = 1'b0; dreq = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid_svc();
        rotate = 1'b0; dreq = 4'b0010;
        tick();
        hlda = 1'b1;
        tick();
        checks++;
        if ({hrq, busy, dack, active_ch} !== 8'b1_1_1101_01) begin
            errors++;
            $display("FAIL midrst_grant got=%b exp=%b", {hrq, busy, dack, active_ch}, 8'b1_1_1101_01);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({hrq, busy, dack, active_ch} !== 8'b0_0_1111_00) begin
            errors++;
            $display("FAIL midrst_reset got=%b exp=%b", {hrq, busy, dack, active_ch}, 8'b0_0_1111_00);
        end
        rst = 1'b0; hlda = 1'b0; dreq = 4'h0;
        tick();
        checks++;
        if ({hrq, busy, dack} !== 6'b0_0_1111) begin
            errors++;
            $display("FAIL midrst_after got=%b exp=%b", {hrq, busy, dack}, 6'b0_0_1111);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_ctrl_en_mask();
        test_rotate();
        test_withdraw();
        test_abort_mask();
        test_rotate_off();
        test_reset_mid_svc();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
